// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing, downscaled frame-memory addressing and colour/sync realignment.
// Optional bar test pattern (input i_testpat) when VGA_SCANOUT_TESTPAT_EN is defined.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 1,
  parameter int COLOR_W     = 12,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic               i_testpat,
`endif
  input  logic [COLOR_W-1:0] i_color,
  output logic [7:0]         o_pxlX,
  output logic [7:0]         o_pxlY,
  output logic [COLOR_W-1:0] o_rgb,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic               o_vblank,
  output logic               o_frame_end
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = COLOR_W / 3;
  localparam int PW = 3 * (RD_LAT + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_ACTIVE >> SCALE_SHIFT) > 256 || (V_ACTIVE >> SCALE_SHIFT) > 256 ||
      COLOR_W % 3 != 0 || RD_LAT > 4 || RD_LAT < 0) begin : g_param_err
    $error("vga_scanout: unsupported parameter set");
  end

  logic [HW-1:0]            hcnt_q, hcnt_d;
  logic [VW-1:0]            vcnt_q, vcnt_d;
  logic                     act, hs, vs;
  logic [7:0]               pxl_x_q, pxl_x_d, pxl_y_q, pxl_y_d;
  logic [RD_LAT:0][2:0]     ctl_q, ctl_d;
  logic                     vblank_q, frame_end_q;
  logic [COLOR_W-1:0]       color;

  always_comb begin
    hcnt_d  = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
    vcnt_d  = (hcnt_q != H_LAST) ? vcnt_q : (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    act     = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    hs      = (hcnt_q >= HS_B) && (hcnt_q < HS_E);
    vs      = (vcnt_q >= VS_B) && (vcnt_q < VS_E);
    pxl_x_d = act ? 8'(hcnt_q >> SCALE_SHIFT) : '0;
    pxl_y_d = act ? 8'(vcnt_q >> SCALE_SHIFT) : '0;
    ctl_d   = PW'({ctl_q, act, hs, vs});
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      pxl_x_q     <= '0;
      pxl_y_q     <= '0;
      ctl_q       <= '0;
      vblank_q    <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      pxl_x_q     <= pxl_x_d;
      pxl_y_q     <= pxl_y_d;
      ctl_q       <= ctl_d;
      vblank_q    <= vcnt_d >= V_ACT;
      frame_end_q <= (hcnt_d == '0) && (vcnt_d == V_ACT);
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  localparam int TW = (COLOR_W + 1) * (RD_LAT + 1);
  logic [RD_LAT:0][COLOR_W:0] tp_q, tp_d;
  logic [2:0]                 bar;
  always_comb begin
    bar  = pxl_x_d[7:5];
    tp_d = TW'({tp_q, i_testpat, {CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}});
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) tp_q <= '0;
    else tp_q <= tp_d;
  end
  assign color = tp_q[RD_LAT][COLOR_W] ? tp_q[RD_LAT][COLOR_W-1:0] : i_color;
`else
  assign color = i_color;
`endif

  // i_color arrives aligned with the last control stage, so it is gated rather than re-registered
  assign o_de        = ctl_q[RD_LAT][2];
  assign o_hsync     = ctl_q[RD_LAT][1] ? SYNC_POL : ~SYNC_POL;
  assign o_vsync     = ctl_q[RD_LAT][0] ? SYNC_POL : ~SYNC_POL;
  assign o_rgb       = o_de ? color : '0;
  assign o_pxlX      = pxl_x_q;
  assign o_pxlY      = pxl_y_q;
  assign o_vblank    = vblank_q;
  assign o_frame_end = frame_end_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of raster timing, reset, pixel realignment and blanking on a
// full-size instance (RD_LAT=1) and a miniature-geometry instance (RD_LAT=2, 24x12 raster).
`timescale 1ns/1ps
module tb_vga_scanout;
  logic clk = 1'b0, rst_n = 1'b0, tp = 1'b0;
  logic [11:0] col_a, col_b, col_b1, rgb_a, rgb_b;
  logic [7:0] xa, ya, xb, yb;
  logic hs_a, vs_a, de_a, vb_a, fe_a, hs_b, vs_b, de_b, vb_b, fe_b;
  int checks = 0, passed = 0, k = 0;

  always #5 clk = ~clk;

  // frame memory models: data = {Y[3:0], X[3:0], 4'h0}, RD_LAT cycles after the address
  always @(posedge clk) begin
    col_a  <= {ya[3:0], xa[3:0], 4'h0};
    col_b1 <= {yb[3:0], xb[3:0], 4'h0};
    col_b  <= col_b1;
  end

  vga_scanout dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .i_testpat(tp),
`endif
    .i_color(col_a), .o_pxlX(xa), .o_pxlY(ya), .o_rgb(rgb_a), .o_hsync(hs_a), .o_vsync(vs_a),
    .o_de(de_a), .o_vblank(vb_a), .o_frame_end(fe_a)
  );

  vga_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE_SHIFT(1), .RD_LAT(2)
  ) dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .i_testpat(tp),
`endif
    .i_color(col_b), .o_pxlX(xb), .o_pxlY(yb), .o_rgb(rgb_b), .o_hsync(hs_b), .o_vsync(vs_b),
    .o_de(de_b), .o_vblank(vb_b), .o_frame_end(fe_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic step_to(input int target);
    step(target - k);
  endtask

  task automatic release_rst();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    int n;
    release_rst();
    step(300);
    rst_n = 1'b0;
    step(1);
    checks++; if (de_a !== 1'b0) $display("FAIL rst_de: got %b want 0", de_a); else passed++;
    checks++; if (rgb_a !== 12'h000) $display("FAIL rst_rgb: got %h want 000", rgb_a); else passed++;
    checks++; if ({hs_a, vs_a} !== 2'b11) $display("FAIL rst_sync: got %b want 11", {hs_a, vs_a}); else passed++;
    checks++; if ({xa, ya} !== 16'h0) $display("FAIL rst_pxl: got %h want 0000", {xa, ya}); else passed++;
    checks++; if ({vb_a, fe_a} !== 2'b00) $display("FAIL rst_vb_fe: got %b want 00", {vb_a, fe_a}); else passed++;
    step(4);
    checks++; if ({de_a, hs_a} !== 2'b01) $display("FAIL rst_hold: got %b want 01", {de_a, hs_a}); else passed++;
    rst_n = 1'b1;
    k = 0;
    n = 0;
    while (hs_a !== 1'b0 && n < 2000) begin step(1); n++; end
    checks++; if (n != 658) $display("FAIL first_hsync: got %0d cycles want 658", n); else passed++;
  endtask

  task automatic test_line();
    int n, p;
    n = 0;
    while (hs_a === 1'b0 && n < 2000) begin step(1); n++; end
    checks++; if (n != 96) $display("FAIL hsync_width: got %0d want 96", n); else passed++;
    p = n;
    while (hs_a !== 1'b0 && p < 2000) begin step(1); p++; end
    checks++; if (p != 800) $display("FAIL hsync_period: got %0d want 800", p); else passed++;
    n = 0;
    while (de_a !== 1'b1 && n < 2000) begin step(1); n++; end
    n = 0;
    while (de_a === 1'b1 && n < 2000) begin step(1); n++; end
    checks++; if (n != 640) $display("FAIL de_width: got %0d want 640", n); else passed++;
    p = n;
    while (de_a !== 1'b1 && p < 2000) begin step(1); p++; end
    checks++; if (p != 800) $display("FAIL de_period: got %0d want 800", p); else passed++;
  endtask

  task automatic test_pixels();
    release_rst();
    step_to(9);
    checks++; if ({de_a, rgb_a} !== 13'h1010) $display("FAIL pix_7_0: got %h want 1010", {de_a, rgb_a}); else passed++;
    step_to(4101);
    checks++; if ({xa, ya} !== 16'h1901) $display("FAIL addr_100_5: got %h want 1901", {xa, ya}); else passed++;
    step_to(4102);
    checks++; if (rgb_a !== 12'h190) $display("FAIL pix_100_5: got %h want 190", rgb_a); else passed++;
    step_to(4641);
    checks++; if (rgb_a !== 12'h1F0) $display("FAIL pix_639_5: got %h want 1f0", rgb_a); else passed++;
    step_to(4642);
    checks++; if ({de_a, rgb_a} !== 13'h0) $display("FAIL pix_640_5: got %h want 0000", {de_a, rgb_a}); else passed++;
    step_to(4701);
    checks++; if (xa !== 8'h00) $display("FAIL addr_blank: got %h want 00", xa); else passed++;
  endtask

  task automatic test_frame();
    int t, h, v, p, bad_de, bad_hs, bad_vs, bad_rgb, bad_vb, bad_fe, bad_blank, vs_low, fe_cnt;
    logic [11:0] exp_rgb;
    logic exp_de;
    bad_de = 0; bad_hs = 0; bad_vs = 0; bad_rgb = 0; bad_vb = 0; bad_fe = 0; bad_blank = 0;
    vs_low = 0; fe_cnt = 0;
    release_rst();
    while (k < 576) begin
      step(1);
      t = k - 3;
      h = (t < 0) ? 100 : t % 24;
      v = (t < 0) ? 100 : (t / 24) % 12;
      p = k % 288;
      exp_de  = (h < 16) && (v < 8);
      exp_rgb = exp_de ? {4'(v >> 1), 4'(h >> 1), 4'h0} : 12'h000;
      if (de_b !== exp_de) bad_de++;
      if (hs_b !== !(h >= 18 && h < 22)) bad_hs++;
      if (vs_b !== !(v >= 9 && v < 11)) bad_vs++;
      if (rgb_b !== exp_rgb) bad_rgb++;
      if (vb_b !== (p / 24 >= 8)) bad_vb++;
      if (fe_b !== (p == 192)) bad_fe++;
      if (de_b === 1'b0 && rgb_b !== 12'h000) bad_blank++;
      if (k <= 288 && vs_b === 1'b0) vs_low++;
      if (fe_b === 1'b1) fe_cnt++;
      if (k == 178) begin
        checks++; if (rgb_b !== 12'h330) $display("FAIL pix_small_7_7: got %h want 330", rgb_b); else passed++;
      end
    end
    checks++; if (bad_de != 0) $display("FAIL frame_de: %0d bad cycles want 0", bad_de); else passed++;
    checks++; if (bad_hs != 0) $display("FAIL frame_hsync: %0d bad cycles want 0", bad_hs); else passed++;
    checks++; if (bad_vs != 0) $display("FAIL frame_vsync: %0d bad cycles want 0", bad_vs); else passed++;
    checks++; if (bad_rgb != 0) $display("FAIL frame_rgb: %0d bad pixels want 0", bad_rgb); else passed++;
    checks++; if (bad_vb != 0) $display("FAIL frame_vblank: %0d bad cycles want 0", bad_vb); else passed++;
    checks++; if (bad_fe != 0) $display("FAIL frame_end: %0d bad cycles want 0", bad_fe); else passed++;
    checks++; if (bad_blank != 0) $display("FAIL blank_rgb: %0d nonzero want 0", bad_blank); else passed++;
    checks++; if (vs_low != 48) $display("FAIL vsync_width: got %0d want 48", vs_low); else passed++;
    checks++; if (fe_cnt != 2) $display("FAIL frame_end_count: got %0d want 2", fe_cnt); else passed++;
  endtask

  task automatic test_reset_vblank();
    release_rst();
    step_to(200);
    checks++; if (vb_b !== 1'b1) $display("FAIL vblank_pre: got %b want 1", vb_b); else passed++;
    rst_n = 1'b0;
    step(1);
    checks++; if ({vb_b, fe_b, de_b} !== 3'b000) $display("FAIL vblank_rst: got %b want 000", {vb_b, fe_b, de_b}); else passed++;
  endtask

`ifdef VGA_SCANOUT_TESTPAT_EN
  task automatic test_testpat();
    tp = 1'b1;
    release_rst();
    step_to(4002);
    checks++; if (rgb_a !== 12'h000) $display("FAIL tp_bar0: got %h want 000", rgb_a); else passed++;
    step_to(4130);
    checks++; if (rgb_a !== 12'h00F) $display("FAIL tp_bar1: got %h want 00f", rgb_a); else passed++;
    step_to(4258);
    checks++; if (rgb_a !== 12'h0F0) $display("FAIL tp_bar2: got %h want 0f0", rgb_a); else passed++;
    step_to(4514);
    checks++; if (rgb_a !== 12'hF00) $display("FAIL tp_bar4: got %h want f00", rgb_a); else passed++;
    tp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_pixels();
    test_frame();
    test_reset_vblank();
`ifdef VGA_SCANOUT_TESTPAT_EN
    test_testpat();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
